// File: rtl/urisc_core.sv
// urisc_core: SUBLEQ processor core with a req/ack memory port.
// Each instruction is three words a, b, c at pc. The core computes
// mem[b] - mem[a], writes it back to mem[b], and branches to c when the
// result is signed <= 0, otherwise falls through to pc+3. A taken branch
// to the instruction's own address halts the core until reset.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   run, step      continuous execution level / single-instruction pulse
//   mem_req/we/addr/wdata  registered memory request, held until mem_ack
//   mem_rdata, mem_ack     memory response, valid when mem_req && mem_ack
//   pc, halted, busy       architectural pc, halt flag, activity flag
//   instr_count    retired-instruction counter (wraps)
//
// state | meaning
// IDLE  | waiting for run or step
// FA    | reading a from mem[pc]
// FB    | reading b from mem[pc+1]
// FC    | reading c from mem[pc+2]
// RA    | reading operand mem[a]
// RB    | reading operand mem[b], result computed on ack
// WB    | writing result to mem[b], pc/counter update on ack
// HALT  | stopped on a halt instruction, left only through rst
module urisc_core #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 11,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              busy,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FA, S_FB, S_FC, S_RA, S_RB, S_WB, S_HALT
  } state_t;

  localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

  state_t            state;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [ADDR_W-1:0] c_addr;
  logic [WIDTH-1:0]  opa;
  logic              take;
  logic [WIDTH-1:0]  diff;
  logic [ADDR_W-1:0] pc_next;
  logic              xfer;

  assign xfer    = mem_req && mem_ack;
  assign diff    = mem_rdata - opa;
  assign pc_next = take ? c_addr : pc + ADDR_W'(3);
  assign busy    = (state != S_IDLE) && (state != S_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC_V;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      halted      <= 1'b0;
      instr_count <= '0;
      a_addr      <= '0;
      b_addr      <= '0;
      c_addr      <= '0;
      opa         <= '0;
      take        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // step is only honoured here; pulses seen while busy are dropped
          if (run || step) begin
            state    <= S_FA;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end
        end
        S_FA: begin
          if (xfer) begin
            a_addr   <= mem_rdata[ADDR_W-1:0];
            mem_addr <= pc + ADDR_W'(1);
            state    <= S_FB;
          end
        end
        S_FB: begin
          if (xfer) begin
            b_addr   <= mem_rdata[ADDR_W-1:0];
            mem_addr <= pc + ADDR_W'(2);
            state    <= S_FC;
          end
        end
        S_FC: begin
          if (xfer) begin
            c_addr   <= mem_rdata[ADDR_W-1:0];
            mem_addr <= a_addr;
            state    <= S_RA;
          end
        end
        S_RA: begin
          if (xfer) begin
            opa      <= mem_rdata;
            mem_addr <= b_addr;
            state    <= S_RB;
          end
        end
        S_RB: begin
          if (xfer) begin
            // branch decision latched here so WB only needs c and pc
            mem_we    <= 1'b1;
            mem_wdata <= diff;
            take      <= (diff == '0) || diff[WIDTH-1];
            state     <= S_WB;
          end
        end
        S_WB: begin
          if (xfer) begin
            pc          <= pc_next;
            instr_count <= instr_count + CNT_W'(1);
            mem_we      <= 1'b0;
            if (take && (c_addr == pc)) begin
              halted  <= 1'b1;
              mem_req <= 1'b0;
              state   <= S_HALT;
            end else if (run) begin
              mem_addr <= pc_next;
              state    <= S_FA;
            end else begin
              mem_req <= 1'b0;
              state   <= S_IDLE;
            end
          end
        end
        S_HALT: begin
          mem_req <= 1'b0;
        end
        default: begin
          mem_req <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_urisc_core.sv
module tb_urisc_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst  = 1'b1;
  logic run  = 1'b0;
  logic step = 1'b0;
  logic sel  = 1'b0;
  int   wait_n = 0;

  logic        req0, we0, halted0, busy0, ack0;
  logic [7:0]  addr0, pc0;
  logic [15:0] wdata0;
  logic [31:0] cnt0;
  logic        req1, we1, halted1, busy1, ack1;
  logic [7:0]  addr1, pc1;
  logic [15:0] wdata1;
  logic [31:0] cnt1;
  logic        rst0, rst1;

  logic        m_req, m_we, m_ack, m_halted, m_busy;
  logic [7:0]  m_addr, m_pc;
  logic [15:0] m_wdata, m_rdata;
  logic [31:0] m_cnt;

  logic [15:0] mem [256];
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = 8'h0;
  logic [15:0] ld_data = 16'h0;
  int          wcnt = 0;

  assign rst0 = rst | sel;
  assign rst1 = rst | ~sel;

  assign m_req    = sel ? req1    : req0;
  assign m_we     = sel ? we1     : we0;
  assign m_addr   = sel ? addr1   : addr0;
  assign m_wdata  = sel ? wdata1  : wdata0;
  assign m_pc     = sel ? pc1     : pc0;
  assign m_halted = sel ? halted1 : halted0;
  assign m_busy   = sel ? busy1   : busy0;
  assign m_cnt    = sel ? cnt1    : cnt0;
  assign m_ack    = m_req && (wcnt == wait_n);
  assign ack0     = m_ack && !sel;
  assign ack1     = m_ack && sel;
  assign m_rdata  = mem[m_addr];

  urisc_core #(.WIDTH(16), .ADDR_W(8), .RESET_PC(11), .CNT_W(32)) u_dut0 (
    .clk(clk), .rst(rst0), .run(run), .step(step),
    .mem_req(req0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
    .mem_rdata(m_rdata), .mem_ack(ack0),
    .pc(pc0), .halted(halted0), .busy(busy0), .instr_count(cnt0)
  );

  urisc_core #(.WIDTH(16), .ADDR_W(8), .RESET_PC(254), .CNT_W(32)) u_dut1 (
    .clk(clk), .rst(rst1), .run(run), .step(step),
    .mem_req(req1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
    .mem_rdata(m_rdata), .mem_ack(ack1),
    .pc(pc1), .halted(halted1), .busy(busy1), .instr_count(cnt1)
  );

  // memory model and bus monitor
  logic [24:0] obs [256];
  int          obs_wr = 0;
  int          busy_cnt = 0;
  int          req_cnt = 0;
  int          unstable = 0;
  logic        hold_v = 1'b0;
  logic [24:0] hold = '0;
  logic [24:0] cur;
  assign cur = {m_we, m_addr, m_wdata};

  always @(posedge clk) begin
    if (m_busy) busy_cnt <= busy_cnt + 1;
    if (m_req) req_cnt <= req_cnt + 1;
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (m_req && m_ack && m_we) mem[m_addr] <= m_wdata;
    if (!m_req || m_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (m_req && m_ack && !rst) begin
      obs[obs_wr[7:0]] <= {m_we, m_addr, m_we ? m_wdata : 16'h0};
      obs_wr <= obs_wr + 1;
    end
    hold_v <= m_req && !m_ack && !rst;
    hold   <= cur;
    if (hold_v && m_req && (hold != cur)) unstable <= unstable + 1;
  end

  int checks = 0;
  int failures = 0;
  int obs_rd = 0;
  logic [24:0] exp_q [$];

  function automatic logic [24:0] acc(bit we, int a, int d);
    return {we, 8'(a), 16'(d)};
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(bit s, int w);
    @(negedge clk);
    rst = 1'b1; run = 1'b0; step = 1'b0; sel = s; wait_n = w;
    tick(2);
    rst = 1'b0;
    exp_q.delete();
    obs_rd = obs_wr;
  endtask

  task automatic ld(int a, int d);
    ld_addr = 8'(a); ld_data = 16'(d); ld_en = 1'b1;
    tick(1);
    ld_en = 1'b0;
  endtask

  task automatic step_and_wait(output int busy_cycles);
    int b0, t;
    b0 = busy_cnt;
    step = 1'b1;
    tick(1);
    step = 1'b0;
    t = 0;
    while (m_busy && t < 400) begin tick(1); t++; end
    checks++;
    if (m_busy) begin failures++; $display("FAIL step_timeout: busy=%0b expected 0", m_busy); end
    busy_cycles = busy_cnt - b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b1; sel = 1'b0; wait_n = 0;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      checks++;
      if (m_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", m_req); end
    end
    checks++;
    if ({m_pc, m_we, m_addr, m_wdata, m_halted, m_busy, m_cnt} !== {8'd11, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL reset_vals: pc=%0d we=%b addr=%0d wdata=%h halted=%b busy=%b cnt=%0d expected pc=11 rest 0",
               m_pc, m_we, m_addr, m_wdata, m_halted, m_busy, m_cnt);
    end
    run = 1'b0;
  endtask

  task automatic test_single_step();
    int bc;
    logic [24:0] e;
    do_reset(0, 0);
    ld(11, 20); ld(12, 21); ld(13, 40); ld(20, 3); ld(21, 5);
    exp_q.push_back(acc(0, 11, 0)); exp_q.push_back(acc(0, 12, 0));
    exp_q.push_back(acc(0, 13, 0)); exp_q.push_back(acc(0, 20, 0));
    exp_q.push_back(acc(0, 21, 0)); exp_q.push_back(acc(1, 21, 2));
    step_and_wait(bc);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_rd == obs_wr) begin failures++; $display("FAIL step_access: got none expected %h", e); end
      else begin
        if (obs[obs_rd[7:0]] !== e) begin failures++; $display("FAIL step_access: got %h expected %h", obs[obs_rd[7:0]], e); end
        obs_rd++;
      end
    end
    checks++;
    if (obs_rd != obs_wr) begin failures++; $display("FAIL step_extra: got %0d extra accesses expected 0", obs_wr - obs_rd); end
    checks++;
    if (m_pc !== 8'd14) begin failures++; $display("FAIL step_pc: got %0d expected 14", m_pc); end
    checks++;
    if (m_cnt !== 32'd1) begin failures++; $display("FAIL step_count: got %0d expected 1", m_cnt); end
    checks++;
    if (bc != 6) begin failures++; $display("FAIL step_busy_cycles: got %0d expected 6", bc); end
    checks++;
    if (mem[21] !== 16'd2) begin failures++; $display("FAIL step_result: got %0d expected 2", mem[21]); end
  endtask

  task automatic test_branch();
    int ta[3] = '{5, 7, 1};
    int tb[3] = '{5, 5, 'h8000};
    logic [15:0] r;
    int bc, epc;
    logic [24:0] e;
    for (int i = 0; i < 3; i++) begin
      do_reset(0, 0);
      ld(11, 20); ld(12, 21); ld(13, 40); ld(20, ta[i]); ld(21, tb[i]);
      r = 16'(tb[i] - ta[i]);
      epc = ((r == 16'h0) || r[15]) ? 40 : 14;
      exp_q.push_back(acc(0, 11, 0)); exp_q.push_back(acc(0, 12, 0));
      exp_q.push_back(acc(0, 13, 0)); exp_q.push_back(acc(0, 20, 0));
      exp_q.push_back(acc(0, 21, 0)); exp_q.push_back(acc(1, 21, r));
      step_and_wait(bc);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_rd == obs_wr) begin failures++; $display("FAIL branch%0d_access: got none expected %h", i, e); end
        else begin
          if (obs[obs_rd[7:0]] !== e) begin failures++; $display("FAIL branch%0d_access: got %h expected %h", i, obs[obs_rd[7:0]], e); end
          obs_rd++;
        end
      end
      checks++;
      if (mem[21] !== r) begin failures++; $display("FAIL branch%0d_result: got %h expected %h", i, mem[21], r); end
      checks++;
      if (m_pc !== 8'(epc)) begin failures++; $display("FAIL branch%0d_pc: got %0d expected %0d", i, m_pc, epc); end
    end
  endtask

  task automatic test_wait_wrap();
    int bc, u0;
    logic [24:0] e;
    do_reset(1, 3);
    checks++;
    if (m_pc !== 8'd254) begin failures++; $display("FAIL wrap_reset_pc: got %0d expected 254", m_pc); end
    ld(254, 20); ld(255, 21); ld(0, 40); ld(20, 3); ld(21, 5);
    exp_q.push_back(acc(0, 254, 0)); exp_q.push_back(acc(0, 255, 0));
    exp_q.push_back(acc(0, 0, 0));   exp_q.push_back(acc(0, 20, 0));
    exp_q.push_back(acc(0, 21, 0));  exp_q.push_back(acc(1, 21, 2));
    u0 = unstable;
    step_and_wait(bc);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_rd == obs_wr) begin failures++; $display("FAIL wrap_access: got none expected %h", e); end
      else begin
        if (obs[obs_rd[7:0]] !== e) begin failures++; $display("FAIL wrap_access: got %h expected %h", obs[obs_rd[7:0]], e); end
        obs_rd++;
      end
    end
    checks++;
    if (unstable != u0) begin failures++; $display("FAIL wrap_stable: got %0d changes expected 0", unstable - u0); end
    checks++;
    if (bc != 24) begin failures++; $display("FAIL wrap_busy_cycles: got %0d expected 24", bc); end
    checks++;
    if (m_pc !== 8'd1) begin failures++; $display("FAIL wrap_pc: got %0d expected 1", m_pc); end
    checks++;
    if (mem[21] !== 16'd2) begin failures++; $display("FAIL wrap_result: got %0d expected 2", mem[21]); end
  endtask

  task automatic test_reset_mid_wb();
    int t;
    do_reset(0, 10);
    ld(11, 20); ld(12, 21); ld(13, 40); ld(20, 3); ld(21, 5);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    t = 0;
    while (!(m_req && m_we) && t < 200) begin tick(1); t++; end
    checks++;
    if (!(m_req && m_we)) begin failures++; $display("FAIL rstwb_timeout: req=%b we=%b expected 1 1", m_req, m_we); end
    tick(2);
    rst = 1'b1;
    tick(1);
    checks++;
    if (m_req !== 1'b0) begin failures++; $display("FAIL rstwb_req: got %b expected 0", m_req); end
    checks++;
    if (m_pc !== 8'd11) begin failures++; $display("FAIL rstwb_pc: got %0d expected 11", m_pc); end
    rst = 1'b0;
  endtask

  task automatic test_halt();
    int t, r0;
    do_reset(0, 0);
    ld(11, 20); ld(12, 20); ld(13, 11); ld(20, 9);
    run = 1'b1;
    t = 0;
    while (!m_halted && t < 100) begin tick(1); t++; end
    checks++;
    if (m_halted !== 1'b1) begin failures++; $display("FAIL halt_flag: got %b expected 1", m_halted); end
    checks++;
    if (mem[20] !== 16'd0) begin failures++; $display("FAIL halt_write: got %0d expected 0", mem[20]); end
    checks++;
    if (m_cnt !== 32'd1) begin failures++; $display("FAIL halt_count: got %0d expected 1", m_cnt); end
    checks++;
    if (m_pc !== 8'd11) begin failures++; $display("FAIL halt_pc: got %0d expected 11", m_pc); end
    r0 = req_cnt;
    for (int i = 0; i < 100; i++) begin
      step = (i % 10 == 3);
      tick(1);
    end
    step = 1'b0;
    checks++;
    if (req_cnt != r0) begin failures++; $display("FAIL halt_quiet: got %0d req cycles expected 0", req_cnt - r0); end
    checks++;
    if (m_busy !== 1'b0 || m_cnt !== 32'd1) begin failures++; $display("FAIL halt_stay: busy=%b cnt=%0d expected 0 1", m_busy, m_cnt); end
    run = 1'b0;
  endtask

  task automatic test_run_step();
    int t, r0;
    do_reset(0, 0);
    ld(11, 31); ld(12, 32); ld(13, 14);
    ld(14, 31); ld(15, 33); ld(16, 17);
    ld(17, 30); ld(18, 30); ld(19, 11);
    ld(30, 0); ld(31, 1); ld(32, 100); ld(33, 50);
    run = 1'b1;
    t = 0;
    while (m_cnt != 32'd4 && t < 200) begin tick(1); t++; end
    t = 0;
    while (!(m_req && !m_we && m_addr == 8'd31) && t < 50) begin tick(1); t++; end
    checks++;
    if (m_pc !== 8'd14 || m_cnt !== 32'd4) begin failures++; $display("FAIL mix_drop_point: pc=%0d cnt=%0d expected 14 4", m_pc, m_cnt); end
    run = 1'b0;
    step = 1'b1;
    tick(1);
    step = 1'b0;
    t = 0;
    while (m_busy && t < 100) begin tick(1); t++; end
    checks++;
    if (m_busy !== 1'b0 || m_halted !== 1'b0) begin failures++; $display("FAIL mix_idle: busy=%b halted=%b expected 0 0", m_busy, m_halted); end
    checks++;
    if (m_cnt !== 32'd5) begin failures++; $display("FAIL mix_count: got %0d expected 5", m_cnt); end
    checks++;
    if (m_pc !== 8'd17) begin failures++; $display("FAIL mix_pc: got %0d expected 17", m_pc); end
    checks++;
    if (mem[32] !== 16'd98 || mem[33] !== 16'd48) begin failures++; $display("FAIL mix_data: got %0d %0d expected 98 48", mem[32], mem[33]); end
    r0 = req_cnt;
    tick(20);
    checks++;
    if (req_cnt != r0) begin failures++; $display("FAIL mix_step_ignored: got %0d req cycles expected 0", req_cnt - r0); end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_branch();
    test_wait_wrap();
    test_reset_mid_wb();
    test_halt();
    test_run_step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
